// File: rtl/dump_ctrl.sv
// dump_ctrl: streams a complete capture buffer from sample RAM to a UART, oldest sample first,
// one byte per RAM read, then pulses dump_finished/clr_capture_done.
module dump_ctrl #(
    parameter int AW    = 9,
    parameter int DW    = 8,
    parameter int DEPTH = 512
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start_dump,
    input  logic          capture_done,
    input  logic [AW-1:0] last_addr,
    output logic          ram_en,
    output logic [AW-1:0] ram_addr,
    input  logic [DW-1:0] ram_rdata,
    output logic [DW-1:0] tx_data,
    output logic          trmt,
    input  logic          tx_done,
    output logic          busy,
    output logic          dump_finished,
    output logic          clr_capture_done
);
    typedef enum logic [2:0] {IDLE, RD, LATCH, SEND, WAIT_TX, DONE} state_t;
    state_t        r_state, w_next;
    logic [AW-1:0] r_rd_ptr;
    logic [AW:0]   r_cnt;
    logic [DW-1:0] r_tx_data;
    logic          w_start, w_last;

    assign w_start          = start_dump && capture_done;
    assign w_last           = r_cnt == (AW+1)'(DEPTH-1);
    assign ram_addr         = r_rd_ptr;
    assign tx_data          = r_tx_data;
    assign clr_capture_done = dump_finished;

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) r_state <= IDLE;
        else r_state <= w_next;

    always_comb begin
        w_next        = r_state;
        ram_en        = 1'b0;
        trmt          = 1'b0;
        busy          = 1'b1;
        dump_finished = 1'b0;
        case (r_state)
            IDLE: begin
                busy = 1'b0;
                if (w_start) w_next = RD;
            end
            RD: begin
                ram_en = 1'b1;
                w_next = LATCH;
            end
            LATCH:   w_next = SEND;
            SEND: begin
                trmt   = 1'b1;
                w_next = WAIT_TX;
            end
            WAIT_TX: if (tx_done) w_next = w_last ? DONE : RD;
            DONE: begin
                dump_finished = 1'b1;
                w_next        = IDLE;
            end
            default: w_next = IDLE;
        endcase
    end

    // Start one past the newest sample so the oldest goes out first; pointer wraps naturally.
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            r_rd_ptr  <= '0;
            r_cnt     <= '0;
            r_tx_data <= '0;
        end else begin
            case (r_state)
                IDLE: if (w_start) begin
                    r_rd_ptr <= last_addr + 1'b1;
                    r_cnt    <= '0;
                end
                LATCH: r_tx_data <= ram_rdata;
                WAIT_TX: if (tx_done && !w_last) begin
                    r_rd_ptr <= r_rd_ptr + 1'b1;
                    r_cnt    <= r_cnt + 1'b1;
                end
                default: ;
            endcase
        end
endmodule

// File: doc/dump_ctrl.md
DUMP_CTRL -- requirements
Module: dump_ctrl

Interface
REQ-001 Parameter: AW, 9, sample RAM address width.
REQ-002 Parameter: DW, 8, sample RAM data width.
REQ-003 Parameter: DEPTH, 512, number of samples per dump; SHALL equal 2**AW.
REQ-004 Port: clk  in  1  sole clock; all state updates on rising edge.
REQ-005 Port: rst_n  in  1  asynchronous active-low reset.
REQ-006 Port: start_dump  in  1  single-cycle dump request from command decoder.
REQ-007 Port: capture_done  in  1  high when the capture buffer holds a complete capture.
REQ-008 Port: last_addr  in  AW  RAM address of the final sample written by the capture stage.
REQ-009 Port: ram_en  out  1  RAM read enable.
REQ-010 Port: ram_addr  out  AW  RAM read address.
REQ-011 Port: ram_rdata  in  DW  RAM read data, valid the cycle after ram_en.
REQ-012 Port: tx_data  out  DW  byte presented to the UART transmitter.
REQ-013 Port: trmt  out  1  single-cycle transmit strobe.
REQ-014 Port: tx_done  in  1  single-cycle pulse when the UART finishes a byte.
REQ-015 Port: busy  out  1  high while a dump is in progress.
REQ-016 Port: dump_finished  out  1  single-cycle pulse after the last byte completes.
REQ-017 Port: clr_capture_done  out  1  single-cycle pulse, coincident with dump_finished.

Function
REQ-018 States: IDLE, RD, LATCH, SEND, WAIT_TX, DONE.
REQ-019 IDLE: start_dump=1 and capture_done=1 -> RD; load rd_ptr=last_addr+1 (mod DEPTH), cnt=0.
REQ-020 IDLE: start_dump with capture_done=0 is ignored; state remains IDLE.
REQ-021 RD: ram_en=1, ram_addr=rd_ptr for exactly one cycle -> LATCH.
REQ-022 LATCH: tx_data <= ram_rdata (registered) -> SEND.
REQ-023 SEND: trmt=1 for exactly one cycle -> WAIT_TX.
REQ-024 WAIT_TX: hold tx_data stable; on tx_done: if cnt==DEPTH-1 -> DONE, else rd_ptr<=rd_ptr+1 (mod DEPTH), cnt<=cnt+1 -> RD.
REQ-025 DONE: dump_finished=1 and clr_capture_done=1 for one cycle -> IDLE.
REQ-026 rd_ptr wraps from DEPTH-1 to 0 without gap; samples are emitted oldest-first, last sample is the one at last_addr.
REQ-027 cnt is AW+1 bits wide; exactly DEPTH bytes are sent per dump.
REQ-028 start_dump while busy=1 is ignored; dump continues unaffected.
REQ-029 tx_done outside WAIT_TX is ignored.
REQ-030 last_addr is sampled only on dump start; later changes do not affect the dump in progress.
REQ-031 busy=1 in every state except IDLE.
REQ-032 ram_en=0 and trmt=0 in all states other than RD and SEND respectively.
REQ-033 Latency: start_dump accepted at cycle N -> ram_en at N+1, trmt at N+3.
REQ-034 Byte-to-byte: tx_done at cycle M -> next ram_en at M+1, next trmt at M+3.

Reset
REQ-035 rst_n low SHALL immediately force IDLE, rd_ptr=0, cnt=0, tx_data=0, all strobes/busy low, regardless of clock.
REQ-036 Reset mid-dump SHALL abort the dump without dump_finished or clr_capture_done.
REQ-037 After rst_n deassertion the block SHALL accept start_dump on the first clock edge.

Verification
REQ-038 last_addr=9'h1FF, RAM[i]=i[7:0], capture_done=1, start_dump -> bytes 00,01,...,FF,00,...,FF (512), then one dump_finished and clr_capture_done pulse.
REQ-039 last_addr=9'h0FF -> first ram_addr=9'h100, address wraps 9'h1FF->9'h000, final ram_addr=9'h0FF.
REQ-040 start_dump with capture_done=0 -> busy, ram_en, trmt stay 0 for 20 cycles.
REQ-041 start_dump pulsed during byte 5 of a dump -> total byte count still 512, single dump_finished.
REQ-042 rst_n asserted while in WAIT_TX of byte 100 -> busy=0 asynchronously, no dump_finished; new dump afterwards starts at last_addr+1.
REQ-043 tx_done delayed 0..50 random cycles per byte -> tx_data stable while waiting, trmt exactly once per byte, timing per REQ-033/034.
